// File: rtl/tc_timer_pkg.sv
// Shared constants for the TC0/TC1 timer/counter: register offsets, CTRL
// field positions, mode codes, FSM states and the byte-lane merge helper.
package tc_timer_pkg;

   localparam logic [1:0] ADDR_CTRL   = 2'd0;
   localparam logic [1:0] ADDR_PRESET = 2'd1;
   localparam logic [1:0] ADDR_COUNT  = 2'd2;

   localparam int CTRL_EN   = 0;
   localparam int CTRL_MODE = 1;  // MODE occupies bits [2:1]
   localparam int CTRL_IM   = 3;

   // Only EN, MODE and IM are storage; everything above reads back as zero.
   localparam logic [31:0] CTRL_MASK = 32'h0000_000F;

   localparam logic [1:0] MODE_ONESHOT = 2'b00;
   localparam logic [1:0] MODE_RELOAD  = 2'b01;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_LOAD = 2'd1,
      ST_CNT  = 2'd2,
      ST_INT  = 2'd3
   } tc_state_e;

   function automatic logic [31:0] merge_bytes(input logic [31:0] old_val,
                                               input logic [31:0] wdata,
                                               input logic [3:0]  be);
      logic [31:0] res;
      res = old_val;
      for (int i = 0; i < 4; i++) begin
         if (be[i]) res[8*i +: 8] = wdata[8*i +: 8];
      end
      return res;
   endfunction

endpackage

// File: rtl/tc_timer_if.sv
// Bus-side view of one timer instance: word offset, byte enables and write
// data from the bridge, combinational read data and the interrupt request.
interface tc_timer_if;
   logic [1:0]  Addr;
   logic [3:0]  Byte_en;
   logic [31:0] WData;
   logic [31:0] RData;
   logic        IRQ;

   modport master (output Addr, Byte_en, WData, input RData, IRQ);
   modport slave  (input Addr, Byte_en, WData, output RData, IRQ);
endinterface

// File: rtl/tc_timer.sv
// Memory-mapped down-counter with one-shot / auto-reload modes and a
// maskable interrupt request; CPU writes to CTRL take priority over the FSM.
module tc_timer
   import tc_timer_pkg::*;
#(
   parameter int COUNT_W = 32
) (
   input logic       clk,
   input logic       reset,
   tc_timer_if.slave bus
);

   logic [31:0]        ctrl_q;
   logic [COUNT_W-1:0] preset_q;
   logic [COUNT_W-1:0] count_q;
   logic               irq_flag;
   tc_state_e          state;

   logic        wr_ctrl;
   logic        wr_preset;
   logic        auto_reload;
   logic [31:0] ctrl_merged;
   logic [31:0] preset_merged;

   assign wr_ctrl     = (bus.Byte_en != 4'b0000) && (bus.Addr == ADDR_CTRL);
   assign wr_preset   = (bus.Byte_en != 4'b0000) && (bus.Addr == ADDR_PRESET);
   assign auto_reload = (ctrl_q[CTRL_MODE +: 2] == MODE_RELOAD);

   assign ctrl_merged   = merge_bytes(ctrl_q, bus.WData, bus.Byte_en) & CTRL_MASK;
   assign preset_merged = merge_bytes(32'(preset_q), bus.WData, bus.Byte_en);

   // NOTE: sequential state uses non-blocking assignments only, so later
   // assignments in this block (the CPU write) override earlier FSM ones.
   always_ff @(posedge clk) begin
      if (reset) begin
         ctrl_q   <= '0;
         preset_q <= '0;
         count_q  <= '0;
         irq_flag <= 1'b0;
         state    <= ST_IDLE;
      end else begin
         unique case (state)
            ST_IDLE: begin
               // Flag drops on entry to LOAD so an auto-reload IRQ spans only INT and IDLE.
               if (ctrl_q[CTRL_EN]) begin
                  irq_flag <= 1'b0;
                  state    <= ST_LOAD;
               end
            end
            ST_LOAD: begin
               count_q  <= preset_q;
               irq_flag <= 1'b0;
               state    <= ST_CNT;
            end
            ST_CNT: begin
               if (!ctrl_q[CTRL_EN]) begin
                  state <= ST_IDLE;
               end else if (count_q > COUNT_W'(1)) begin
                  count_q <= count_q - COUNT_W'(1);
               end else begin
                  count_q  <= '0;
                  irq_flag <= 1'b1;
                  state    <= ST_INT;
               end
            end
            ST_INT: begin
               if (!auto_reload) ctrl_q[CTRL_EN] <= 1'b0;
               state <= ST_IDLE;
            end
            default: state <= ST_IDLE;
         endcase

         // A CTRL write is the one-shot acknowledge and beats the EN clear above.
         if (wr_ctrl) begin
            ctrl_q <= ctrl_merged;
            if (!auto_reload) irq_flag <= 1'b0;
         end
         if (wr_preset) preset_q <= preset_merged[COUNT_W-1:0];
      end
   end

   // NOTE: every output of this block gets a default first, so no latch is inferred.
   always_comb begin
      bus.RData = '0;
      unique case (bus.Addr)
         ADDR_CTRL:   bus.RData = ctrl_q;
         ADDR_PRESET: bus.RData = 32'(preset_q);
         ADDR_COUNT:  bus.RData = 32'(count_q);
         default:     bus.RData = '0;
      endcase
   end

   assign bus.IRQ = ctrl_q[CTRL_IM] & irq_flag;

endmodule
